row_memory_controller: RTL and testbench

ROW_MEMORY_CONTROLLER -- requirements
Module: row_memory_controller

---
 rtl/row_memory_controller_pkg.sv | 27 ++
 rtl/row_memory_controller_port.sv | 66 ++++++
 rtl/row_memory_controller.sv | 167 ++++++++++++++++
 tb/tb_row_memory_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/row_memory_controller_pkg.sv
// Shared row/word geometry, FSM state encoding and the row-to-word-address helper.
package row_memory_controller_pkg;

  localparam int unsigned ROW_BITS  = 640;
  localparam int unsigned WORD_BITS = 16;
  localparam int unsigned ROW_WORDS = 40;
  localparam int unsigned NUM_ROWS  = 480;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned ROW_IDX_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } state_t;

  // Base word address of a row; the 40-word case reduces to row*32 + row*8.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_IDX_W-1:0] r,
                                                 input int unsigned words);
    logic [31:0] prod;
    prod = 32'(r) * words;
    if (words == 40) return (ADDR_W'(r) << 5) + (ADDR_W'(r) << 3);
    return prod[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/row_memory_controller_port.sv
// Single SRAM word access: holds address/data/direction for WAIT_CYCLES+1 cycles.
module sram_word_port
  import row_memory_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_write,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [WORD_BITS-1:0] i_wdata,
  output logic                 o_done,
  output logic [WORD_BITS-1:0] o_rdata,
  output logic [ADDR_W-1:0]    o_mem_addr,
  output logic [WORD_BITS-1:0] o_mem_wdata,
  input  logic [WORD_BITS-1:0] i_mem_rdata,
  output logic                 o_mem_we,
  output logic                 o_mem_oe
);

  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  logic                 r_active;
  logic [CW-1:0]        r_cnt;
  logic [ADDR_W-1:0]    r_addr;
  logic [WORD_BITS-1:0] r_wdata;
  logic                 r_we;
  logic                 r_oe;

  // A new start on the done cycle wins, so consecutive words run with no gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_oe     <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_addr   <= i_addr;
      r_wdata  <= i_write ? i_wdata : '0;
      r_we     <= i_write;
      r_oe     <= !i_write;
    end else if (r_active) begin
      if (r_cnt == CNT_LAST) begin
        r_active <= 1'b0;
        r_we     <= 1'b0;
        r_oe     <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_done      = r_active && (r_cnt == CNT_LAST);
  assign o_rdata     = i_mem_rdata;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_we    = r_we;
  assign o_mem_oe    = r_oe;

endmodule

// File: rtl/row_memory_controller.sv
// Row transfer FSM: writes the computed row back to the previous address, then reads the new row.
module row_memory_controller
  import row_memory_controller_pkg::*;
#(
  parameter int unsigned WORDS       = ROW_WORDS,
  parameter int unsigned ROWS        = NUM_ROWS,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                         clkDiv,
  input  logic                         rstN,
  input  logic                         rowStart,
  input  logic [8:0]                   row,
  input  logic [WORDS*WORD_BITS-1:0]   writeRow,
  output logic [WORDS*WORD_BITS-1:0]   readRow,
  output logic                         reading,
  output logic                         busy,
  output logic                         overrun,
  output logic [14:0]                  memAddr,
  output logic [15:0]                  memDataOut,
  input  logic [15:0]                  memDataIn,
  output logic                         memWe,
  output logic                         memOe
);

  localparam int unsigned RB = WORDS * WORD_BITS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);
  localparam logic [9:0] ROWS_L = 10'(ROWS);

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [8:0]           r_cur_row;
  logic [8:0]           r_prev_row;
  logic                 r_prev_valid;
  logic [RB-1:0]        r_shadow;
  logic [RB-1:0]        r_read_row;
  logic [ADDR_W-1:0]    r_base;
  logic                 r_reading;
  logic                 r_busy;
  logic                 r_overrun;

  logic                 w_row_ok;
  logic                 w_idle;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_done;
  logic                 w_last;
  logic [KW-1:0]        w_k_next;
  logic                 w_start;
  logic                 w_write;
  logic [ADDR_W-1:0]    w_addr;
  logic [WORD_BITS-1:0] w_wdata;
  logic [WORD_BITS-1:0] w_rdata;

  assign w_row_ok = ({1'b0, row} < ROWS_L);
  assign w_idle   = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = rowStart && w_row_ok && w_idle;
  assign w_drop   = rowStart && w_row_ok && !w_idle;
  assign w_last   = (r_k == K_LAST);
  assign w_k_next = r_k + KW'(1);

  // Next word launch is decided on the done cycle so the port never idles between words.
  always_comb begin
    w_start = 1'b0;
    w_write = 1'b0;
    w_addr  = r_base + ADDR_W'(w_k_next);
    w_wdata = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (w_k_next == KW'(i)) w_wdata = r_shadow[i*WORD_BITS +: WORD_BITS];
    end
    if (w_accept) begin
      w_start = 1'b1;
      w_write = r_prev_valid;
      w_addr  = r_prev_valid ? row_base(r_prev_row, WORDS) : row_base(row, WORDS);
      w_wdata = writeRow[WORD_BITS-1:0];
    end else if (w_done && r_state == ST_WRITE) begin
      w_start = 1'b1;
      w_write = !w_last;
      if (w_last) w_addr = row_base(r_cur_row, WORDS);
    end else if (w_done && r_state == ST_READ && !w_last) begin
      w_start = 1'b1;
    end
  end

  always_ff @(posedge clkDiv or negedge rstN) begin
    if (!rstN) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_cur_row    <= '0;
      r_prev_row   <= '0;
      r_prev_valid <= 1'b0;
      r_shadow     <= '0;
      r_read_row   <= '0;
      r_base       <= '0;
      r_reading    <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= w_drop;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_cur_row <= row;
            r_shadow  <= writeRow;
            r_k       <= '0;
            r_base    <= w_addr;
            r_reading <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= r_prev_valid ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_done) begin
            if (w_last) begin
              r_k     <= '0;
              r_base  <= w_addr;
              r_state <= ST_READ;
            end else begin
              r_k <= w_k_next;
            end
          end
        end
        ST_READ: begin
          if (w_done) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
              if (r_k == KW'(i)) r_read_row[i*WORD_BITS +: WORD_BITS] <= w_rdata;
            end
            if (w_last) begin
              r_state      <= ST_DONE;
              r_reading    <= 1'b1;
              r_busy       <= 1'b0;
              r_prev_row   <= r_cur_row;
              r_prev_valid <= 1'b1;
            end else begin
              r_k <= w_k_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sram_word_port #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_port (
    .i_clk      (clkDiv),
    .i_rst_n    (rstN),
    .i_start    (w_start),
    .i_write    (w_write),
    .i_addr     (w_addr),
    .i_wdata    (w_wdata),
    .o_done     (w_done),
    .o_rdata    (w_rdata),
    .o_mem_addr (memAddr),
    .o_mem_wdata(memDataOut),
    .i_mem_rdata(memDataIn),
    .o_mem_we   (memWe),
    .o_mem_oe   (memOe)
  );

  assign readRow = r_read_row;
  assign reading = r_reading;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_row_memory_controller.sv
// Directed bench: two controllers (WAIT_CYCLES 1 and 3) each against its own SRAM model.
module tb_row_memory_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstN;
  logic         rowStart, rowStart3;
  logic [8:0]   row, row3;
  logic [639:0] writeRow, writeRow3, readRow, readRow3;
  logic         reading, busy, overrun, memWe, memOe;
  logic         reading3, busy3, overrun3, memWe3, memOe3;
  logic [14:0]  memAddr, memAddr3;
  logic [15:0]  memDataOut, memDataIn, memDataOut3, memDataIn3;

  logic [15:0] mem  [0:19199];
  logic [15:0] mem3 [0:19199];

  always @(posedge clk) if (memWe && memAddr < 15'd19200) mem[memAddr] <= memDataOut;
  always @(posedge clk) if (memWe3 && memAddr3 < 15'd19200) mem3[memAddr3] <= memDataOut3;
  assign memDataIn  = (memOe && memAddr < 15'd19200) ? mem[memAddr] : 16'h0;
  assign memDataIn3 = (memOe3 && memAddr3 < 15'd19200) ? mem3[memAddr3] : 16'h0;

  row_memory_controller dut (
    .clkDiv(clk), .rstN(rstN), .rowStart(rowStart), .row(row), .writeRow(writeRow),
    .readRow(readRow), .reading(reading), .busy(busy), .overrun(overrun),
    .memAddr(memAddr), .memDataOut(memDataOut), .memDataIn(memDataIn),
    .memWe(memWe), .memOe(memOe)
  );

  row_memory_controller #(.WAIT_CYCLES(3)) dut3 (
    .clkDiv(clk), .rstN(rstN), .rowStart(rowStart3), .row(row3), .writeRow(writeRow3),
    .readRow(readRow3), .reading(reading3), .busy(busy3), .overrun(overrun3),
    .memAddr(memAddr3), .memDataOut(memDataOut3), .memDataIn(memDataIn3),
    .memWe(memWe3), .memOe(memOe3)
  );

  int total = 0;
  int bad = 0;

  // Per-transfer observations, cycle n = interval after the n-th edge following acceptance.
  int m_rise, m_we, m_oe, m_fwe, m_lwe, m_foe, m_loe, m_ovr, m_ovr_at, m_both, m_rd1, m_chg;
  logic [14:0] m_prev;
  bit m_pact;

  task automatic start_req(input bit sel, input logic [8:0] r, input logic [639:0] wr);
    @(negedge clk);
    if (sel) begin rowStart3 = 1'b1; row3 = r; writeRow3 = wr; end
    else begin rowStart = 1'b1; row = r; writeRow = wr; end
    @(posedge clk);
    #1;
    rowStart  = 1'b0;
    rowStart3 = 1'b0;
  endtask

  task automatic run_xfer(input bit sel, input int max_cyc, input int inj_cyc, input int stop_cyc);
    logic s_we, s_oe, s_rd, s_ov;
    logic [14:0] s_a;
    m_rise = 0; m_we = 0; m_oe = 0; m_fwe = -1; m_lwe = -1; m_foe = -1; m_loe = -1;
    m_ovr = 0; m_ovr_at = 0; m_both = 0; m_rd1 = -1; m_chg = 0; m_pact = 1'b0;
    m_prev = sel ? memAddr3 : memAddr;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (inj_cyc > 0 && n == inj_cyc) begin rowStart = 1'b1; row = 9'd10; end
      else if (inj_cyc > 0 && n == inj_cyc + 1) rowStart = 1'b0;
      s_we = sel ? memWe3 : memWe;
      s_oe = sel ? memOe3 : memOe;
      s_rd = sel ? reading3 : reading;
      s_ov = sel ? overrun3 : overrun;
      s_a  = sel ? memAddr3 : memAddr;
      if (s_we) begin m_we++; if (m_fwe < 0) m_fwe = int'(s_a); m_lwe = int'(s_a); end
      if (s_oe) begin m_oe++; if (m_foe < 0) m_foe = int'(s_a); m_loe = int'(s_a); end
      if (s_we && s_oe) m_both++;
      if ((s_we || s_oe) && m_pact && s_a != m_prev) m_chg++;
      m_pact = s_we || s_oe;
      m_prev = s_a;
      if (s_ov) begin m_ovr++; m_ovr_at = n; end
      if (n == 1) m_rd1 = int'(s_rd);
      if (s_rd) begin m_rise = n; return; end
      if (n == stop_cyc) return;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    #2 rstN = 1'b0;
    repeat (2) @(negedge clk);
    if (reading !== 1'b0) begin $display("FAIL reset_reading got=%0b exp=0", reading); bad++; end total++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%0b exp=0", busy); bad++; end total++;
    if (overrun !== 1'b0) begin $display("FAIL reset_overrun got=%0b exp=0", overrun); bad++; end total++;
    if ({memWe, memOe} !== 2'b00) begin $display("FAIL reset_we_oe got=%b exp=00", {memWe, memOe}); bad++; end total++;
    if (memAddr !== 15'd0) begin $display("FAIL reset_addr got=%0d exp=0", memAddr); bad++; end total++;
    if (memDataOut !== 16'h0) begin $display("FAIL reset_dout got=%h exp=0000", memDataOut); bad++; end total++;
    if (readRow !== '0) begin $display("FAIL reset_readrow got=%h exp=0", readRow); bad++; end total++;
    rstN = 1'b1;
  endtask

  task automatic test_invalid_row();
    logic [8:0] rows [2];
    rows[0] = 9'd480;
    rows[1] = 9'd511;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rowStart = 1'b1; row = rows[i];
      @(posedge clk); #1 rowStart = 1'b0;
      @(negedge clk);
      if (overrun !== 1'b0) begin $display("FAIL inv_overrun row=%0d got=%0b exp=0", rows[i], overrun); bad++; end total++;
      if (busy !== 1'b0) begin $display("FAIL inv_busy row=%0d got=%0b exp=0", rows[i], busy); bad++; end total++;
      if (memAddr !== 15'd0 || memOe !== 1'b0) begin
        $display("FAIL inv_mem row=%0d got addr=%0d oe=%0b exp addr=0 oe=0", rows[i], memAddr, memOe); bad++;
      end total++;
    end
  endtask

  task automatic test_first_read();
    start_req(1'b0, 9'd5, '0);
    run_xfer(1'b0, 200, 0, 0);
    if (m_rise !== 81) begin $display("FAIL first_rise got=%0d exp=81", m_rise); bad++; end total++;
    if (m_we !== 0) begin $display("FAIL first_we_cycles got=%0d exp=0", m_we); bad++; end total++;
    if (m_oe !== 80 || m_foe !== 200 || m_loe !== 239) begin
      $display("FAIL first_read_addrs got oe=%0d first=%0d last=%0d exp 80/200/239", m_oe, m_foe, m_loe); bad++;
    end total++;
    if (readRow[15:0] !== 16'h0500) begin $display("FAIL first_word0 got=%h exp=0500", readRow[15:0]); bad++; end total++;
    if (readRow[639:624] !== 16'h0527) begin $display("FAIL first_word39 got=%h exp=0527", readRow[639:624]); bad++; end total++;
    if (busy !== 1'b0) begin $display("FAIL first_busy_done got=%0b exp=0", busy); bad++; end total++;
  endtask

  task automatic test_writeback();
    logic [639:0] pat;
    int errs;
    for (int k = 0; k < 40; k++) pat[k*16 +: 16] = (k % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
    start_req(1'b0, 9'd6, pat);
    run_xfer(1'b0, 300, 0, 0);
    if (m_rd1 !== 0) begin $display("FAIL wb_reading_fall got=%0d exp=0", m_rd1); bad++; end total++;
    if (m_rise !== 161) begin $display("FAIL wb_rise got=%0d exp=161", m_rise); bad++; end total++;
    if (m_we !== 80 || m_fwe !== 200 || m_lwe !== 239) begin
      $display("FAIL wb_write_addrs got we=%0d first=%0d last=%0d exp 80/200/239", m_we, m_fwe, m_lwe); bad++;
    end total++;
    if (m_oe !== 80 || m_foe !== 240 || m_loe !== 279) begin
      $display("FAIL wb_read_addrs got oe=%0d first=%0d last=%0d exp 80/240/279", m_oe, m_foe, m_loe); bad++;
    end total++;
    if (m_both !== 0) begin $display("FAIL wb_we_oe_overlap got=%0d exp=0", m_both); bad++; end total++;
    errs = 0;
    for (int k = 0; k < 40; k++) if (mem[200+k] !== ((k % 2 == 0) ? 16'hA5A5 : 16'h5A5A)) errs++;
    if (errs !== 0) begin $display("FAIL wb_sram_pattern got=%0d bad words exp=0", errs); bad++; end total++;
    if (readRow[15:0] !== 16'h0600 || readRow[639:624] !== 16'h0627) begin
      $display("FAIL wb_readrow got w0=%h w39=%h exp 0600/0627", readRow[15:0], readRow[639:624]); bad++;
    end total++;
  endtask

  task automatic test_overrun();
    start_req(1'b0, 9'd7, {40{16'hC3C3}});
    run_xfer(1'b0, 300, 40, 0);
    if (m_ovr !== 1 || m_ovr_at !== 41) begin
      $display("FAIL ovr_pulse got count=%0d at=%0d exp count=1 at=41", m_ovr, m_ovr_at); bad++;
    end total++;
    if (m_rise !== 161) begin $display("FAIL ovr_rise got=%0d exp=161", m_rise); bad++; end total++;
    if (m_fwe !== 240 || m_lwe !== 279 || m_foe !== 280 || m_loe !== 319) begin
      $display("FAIL ovr_addrs got w=%0d..%0d r=%0d..%0d exp w=240..279 r=280..319", m_fwe, m_lwe, m_foe, m_loe); bad++;
    end total++;
    if (readRow[15:0] !== 16'h0700 || mem[240] !== 16'hC3C3) begin
      $display("FAIL ovr_data got rd=%h mem240=%h exp 0700/c3c3", readRow[15:0], mem[240]); bad++;
    end total++;
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 9'd8, '0);
    run_xfer(1'b0, 300, 0, 121);
    if (memOe !== 1'b1 || memAddr !== 15'd340) begin
      $display("FAIL mid_pre got oe=%0b addr=%0d exp oe=1 addr=340", memOe, memAddr); bad++;
    end total++;
    #2 rstN = 1'b0;
    #1;
    if ({reading, busy, overrun, memWe, memOe} !== 5'b0) begin
      $display("FAIL mid_async_flags got=%b exp=00000", {reading, busy, overrun, memWe, memOe}); bad++;
    end total++;
    if (memAddr !== 15'd0 || memDataOut !== 16'h0 || readRow !== '0) begin
      $display("FAIL mid_async_data got addr=%0d dout=%h rowzero=%0b exp 0/0000/1", memAddr, memDataOut, readRow == '0); bad++;
    end total++;
    @(negedge clk) rstN = 1'b1;
    start_req(1'b0, 9'd3, {40{16'hFFFF}});
    run_xfer(1'b0, 300, 0, 0);
    if (m_we !== 0) begin $display("FAIL mid_no_writeback got=%0d exp=0", m_we); bad++; end total++;
    if (m_rise !== 81 || m_foe !== 120) begin
      $display("FAIL mid_next_read got rise=%0d first=%0d exp 81/120", m_rise, m_foe); bad++;
    end total++;
    if (readRow[31:0] !== 32'h0301_0300) begin $display("FAIL mid_readrow got=%h exp=03010300", readRow[31:0]); bad++; end total++;
  endtask

  task automatic test_wait3();
    start_req(1'b1, 9'd479, '0);
    run_xfer(1'b1, 400, 0, 0);
    if (m_rise !== 161) begin $display("FAIL w3_rise got=%0d exp=161", m_rise); bad++; end total++;
    if (m_we !== 0 || m_oe !== 160 || m_chg !== 39) begin
      $display("FAIL w3_hold got we=%0d oe=%0d chg=%0d exp 0/160/39", m_we, m_oe, m_chg); bad++;
    end total++;
    if (m_foe !== 19160 || m_loe !== 19199) begin
      $display("FAIL w3_addrs got %0d..%0d exp 19160..19199", m_foe, m_loe); bad++;
    end total++;
    if (readRow3[15:0] !== 16'd19160 || readRow3[639:624] !== 16'd19199) begin
      $display("FAIL w3_readrow got w0=%0d w39=%0d exp 19160/19199", readRow3[15:0], readRow3[639:624]); bad++;
    end total++;
    start_req(1'b1, 9'd0, {40{16'hBEEF}});
    run_xfer(1'b1, 500, 0, 0);
    if (m_rise !== 321) begin $display("FAIL w3wb_rise got=%0d exp=321", m_rise); bad++; end total++;
    if (m_we !== 160 || m_fwe !== 19160 || m_lwe !== 19199 || m_chg !== 79) begin
      $display("FAIL w3wb_write got we=%0d %0d..%0d chg=%0d exp 160 19160..19199 79", m_we, m_fwe, m_lwe, m_chg); bad++;
    end total++;
    if (m_foe !== 0 || m_loe !== 39 || mem3[19199] !== 16'hBEEF) begin
      $display("FAIL w3wb_read got %0d..%0d mem=%h exp 0..39 beef", m_foe, m_loe, mem3[19199]); bad++;
    end total++;
    if (readRow3[15:0] !== 16'd0 || readRow3[639:624] !== 16'd39) begin
      $display("FAIL w3wb_readrow got w0=%0d w39=%0d exp 0/39", readRow3[15:0], readRow3[639:624]); bad++;
    end total++;
  endtask

  initial begin
    rowStart = 1'b0; rowStart3 = 1'b0; row = '0; row3 = '0; writeRow = '0; writeRow3 = '0;
    for (int r = 0; r < 480; r++)
      for (int k = 0; k < 40; k++) mem[r*40 + k] = 16'((r << 8) + k);
    for (int a = 0; a < 19200; a++) mem3[a] = 16'(a);
    test_reset();
    test_invalid_row();
    test_first_read();
    test_writeback();
    test_overrun();
    test_reset_mid();
    test_wait3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
